// File: rtl/frame_sched_pkg.sv
// Shared types for the frame round-robin scheduler.
// Word type, issue FSM states and ID width helper.
package frame_sched_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over the request vector.
// Search starts one past rr_ptr and wraps explicitly.
module rr_arbiter
  import frame_sched_pkg::*;
#(
  parameter int NB_SRC = 4,
  localparam int SW = src_w(NB_SRC)
) (
  input  logic [NB_SRC-1:0] req,
  input  logic [SW-1:0]     rr_ptr,
  output logic              grant_valid,
  output logic [SW-1:0]     grant_idx
);

  // first requester after rr_ptr, modulo NB_SRC
  always_comb begin
    int idx;
    logic [SW-1:0] sel;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    sel         = '0;
    for (int i = 1; i <= NB_SRC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NB_SRC) idx = idx - NB_SRC;
      sel = SW'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/frame_rr_scheduler.sv
// Round-robin frame issue to a shared ping-pong engine,
// with source tagging of results via a small tag FIFO.
module frame_rr_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NB_SRC     = 4,
  parameter int IN_LENGTH  = 16,
  parameter int OUT_LENGTH = 16,
  parameter int TAG_DEPTH  = 2,
  localparam int SW = src_w(NB_SRC)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NB_SRC-1:0] req_valid,
  input  logic [0:NB_SRC-1][0:IN_LENGTH-1][WORD_W-1:0] req_data,
  output logic [NB_SRC-1:0] req_ack,
  output logic [0:IN_LENGTH-1][WORD_W-1:0] mod_idata,
  output logic mod_ien_data,
  output logic mod_ien,
  input  logic mod_full,
  input  logic [0:OUT_LENGTH-1][WORD_W-1:0] mod_odata,
  input  logic mod_oen,
  output logic mod_fct,
  output logic [0:OUT_LENGTH-1][WORD_W-1:0] res_data,
  output logic [SW-1:0] res_src,
  output logic res_valid,
  input  logic res_ready,
  output logic busy,
  output logic err_orphan
);

  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  state_t state, state_nx;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant_q;
  logic          arb_valid;
  logic [SW-1:0] arb_idx;
  logic          can_issue;

  logic [SW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] tag_count;
  logic          push;
  logic          pop;

  rr_arbiter #(
    .NB_SRC(NB_SRC)
  ) u_arb (
    .req        (req_valid),
    .rr_ptr     (rr_ptr),
    .grant_valid(arb_valid),
    .grant_idx  (arb_idx)
  );

  assign can_issue = arb_valid && !mod_full &&
                     (tag_count < CW'(TAG_DEPTH));
  assign push      = (state == ISSUE);
  assign pop       = mod_oen && (tag_count != '0);
  assign mod_fct   = res_valid && !res_ready;
  assign busy      = (state != IDLE) || (tag_count != '0) ||
                     res_valid;

  // next state and issue strobes
  always_comb begin
    state_nx     = state;
    mod_ien      = 1'b0;
    mod_ien_data = 1'b0;
    req_ack      = '0;
    unique case (state)
      IDLE: begin
        if (can_issue) state_nx = ISSUE;
      end
      ISSUE: begin
        mod_ien          = 1'b1;
        mod_ien_data     = 1'b1;
        req_ack[grant_q] = 1'b1;
        state_nx         = SETTLE;
      end
      SETTLE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register, grant capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= SW'(NB_SRC - 1);
      grant_q   <= '0;
      mod_idata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && can_issue) begin
        grant_q   <= arb_idx;
        mod_idata <= req_data[arb_idx];
      end
      if (push) rr_ptr <= grant_q;
    end
  end

  // tag storage, written on issue
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_q;
  end

  // tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(TAG_DEPTH - 1)) ?
                  '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ?
                  '0 : rd_ptr + PW'(1);
      end
      if (push && !pop)
        tag_count <= tag_count + CW'(1);
      else if (pop && !push)
        tag_count <= tag_count - CW'(1);
    end
  end

  // result holding register and orphan flag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data   <= '0;
      res_src    <= '0;
      res_valid  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (pop) begin
        res_data  <= mod_odata;
        res_src   <= tag_mem[rd_ptr];
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (mod_oen && tag_count == '0) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Directed bench for frame_rr_scheduler with a behavioural
// ping-pong engine model that inverts every word.
module tb_frame_rr_scheduler;

  localparam int NB = 4;
  localparam int IL = 16;
  localparam int OL = 16;

  typedef logic [0:IL-1][31:0] frame_t;
  typedef struct {
    int     src;
    frame_t d;
  } rx_t;
  typedef struct {
    logic [3:0] req;
    int         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0] req_valid;
  logic [0:NB-1][0:IL-1][31:0] req_data;
  logic [NB-1:0] req_ack;
  frame_t mod_idata;
  logic mod_ien_data;
  logic mod_ien;
  logic mod_full;
  logic [0:OL-1][31:0] mod_odata;
  logic mod_oen;
  logic mod_fct;
  logic [0:OL-1][31:0] res_data;
  logic [1:0] res_src;
  logic res_valid;
  logic res_ready;
  logic busy;
  logic err_orphan;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat = 1;
  bit full_mode = 0;
  bit full_force = 0;
  bit full_auto = 0;

  frame_t pend[$];
  int     pcyc[$];
  int     ack_q[$];
  rx_t    rx_q[$];
  vec_t   tbl[10];

  assign mod_full = full_mode ? full_force : full_auto;

  frame_rr_scheduler #(
    .NB_SRC(NB), .IN_LENGTH(IL),
    .OUT_LENGTH(OL), .TAG_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .mod_idata(mod_idata),
    .mod_ien_data(mod_ien_data), .mod_ien(mod_ien),
    .mod_full(mod_full), .mod_odata(mod_odata),
    .mod_oen(mod_oen), .mod_fct(mod_fct),
    .res_data(res_data), .res_src(res_src),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] wv(input int s, input int k);
    return 32'(s * 256 + k);
  endfunction

  function automatic bit frame_ok(input frame_t d, input int s,
                                  input bit inv);
    bit ok = 1;
    for (int k = 0; k < IL; k++) begin
      if (d[k] !== (inv ? ~wv(s, k) : wv(s, k))) ok = 0;
    end
    return ok;
  endfunction

  function automatic int oh2idx(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int idx);
    int t = 0;
    idx = -1;
    do begin
      tick();
      t++;
    end while (req_ack == '0 && t < 50);
    if (req_ack != '0) idx = oh2idx(req_ack);
    else chk("ack_timeout", 0, 1);
  endtask

  task automatic drain(input int n, input string nm);
    int t = 0;
    while ((rx_q.size() < n || busy) && t < 400) begin
      tick();
      t++;
    end
    chk(nm, (rx_q.size() == n) && !busy, 1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // engine model, issue monitor and result capture
  always @(negedge clk) begin
    if (!rst && (req_ack != '0 || mod_ien || mod_ien_data)) begin
      chk("issue_strobes",
          {$onehot(req_ack), mod_ien, mod_ien_data}, 3'b111);
      if ($onehot(req_ack)) begin
        ack_q.push_back(oh2idx(req_ack));
        chk("issue_frame",
            frame_ok(mod_idata, oh2idx(req_ack), 0), 1);
      end
    end
    if (res_valid && res_ready)
      rx_q.push_back('{int'(res_src), res_data});
    mod_oen = 1'b0;
    if (pend.size() > 0 && !mod_fct && (cyc - pcyc[0] >= lat)) begin
      for (int k = 0; k < OL; k++) mod_odata[k] = ~pend[0][k];
      void'(pend.pop_front());
      void'(pcyc.pop_front());
      mod_oen = 1'b1;
    end
    if (mod_ien) begin
      pend.push_back(mod_idata);
      pcyc.push_back(cyc);
    end
    full_auto = (pend.size() >= 2);
  end

  initial begin
    int g;
    int t;
    int cnt [NB];

    tbl[0] = '{4'b0001, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1001, 3};
    tbl[4] = '{4'b1001, 0};
    tbl[5] = '{4'b0100, 2};
    tbl[6] = '{4'b0011, 0};
    tbl[7] = '{4'b1010, 1};
    tbl[8] = '{4'b1000, 3};
    tbl[9] = '{4'b0110, 1};

    for (int s = 0; s < NB; s++)
      for (int k = 0; k < IL; k++) req_data[s][k] = wv(s, k);
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    mod_oen = 1'b0;
    mod_odata = '0;

    // reset state
    tick();
    tick();
    chk("rst_outs",
        {req_ack, mod_ien, mod_ien_data, mod_fct,
         res_valid, busy, err_orphan, res_src}, 0);
    chk("rst_data", (mod_idata == '0) && (res_data == '0), 1);
    rst = 1'b0;

    // round-robin grant table
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].req;
      wait_ack(g);
      chk($sformatf("tbl_grant%0d", i), g, tbl[i].exp);
      req_valid = '0;
    end
    drain(10, "tbl_drain");
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      chk($sformatf("tbl_src%0d", i), rx_q[i].src, tbl[i].exp);
      chk($sformatf("tbl_data%0d", i),
          frame_ok(rx_q[i].d, tbl[i].exp, 1), 1);
    end

    // single source latency and strobe width
    rx_q.delete();
    req_valid = 4'b0001;
    tick();
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_ien", {mod_ien, mod_ien_data}, 2'b11);
    chk("t1_idata", frame_ok(mod_idata, 0, 0), 1);
    req_valid = '0;
    tick();
    chk("t1_ien_off", {mod_ien, mod_ien_data, req_ack}, 0);
    drain(1, "t1_drain");
    if (rx_q.size() > 0) begin
      chk("t1_src", rx_q[0].src, 0);
      chk("t1_data", frame_ok(rx_q[0].d, 0, 1), 1);
    end

    // all sources requesting continuously
    do_reset();
    ack_q.delete();
    rx_q.delete();
    req_valid = 4'b1111;
    t = 0;
    while (ack_q.size() < 12 && t < 300) begin
      tick();
      t++;
    end
    req_valid = '0;
    drain(12, "t2_drain");
    chk("t2_nack", ack_q.size(), 12);
    for (int i = 0; i < NB; i++) cnt[i] = 0;
    for (int i = 0; i < 12 && i < ack_q.size(); i++) begin
      chk($sformatf("t2_order%0d", i), ack_q[i], i % NB);
      cnt[ack_q[i]]++;
      if (i < rx_q.size()) begin
        chk($sformatf("t2_src%0d", i), rx_q[i].src, ack_q[i]);
        chk($sformatf("t2_data%0d", i),
            frame_ok(rx_q[i].d, ack_q[i], 1), 1);
      end
    end
    chk("t2_fair", {cnt[0], cnt[1], cnt[2], cnt[3]},
        {32'd3, 32'd3, 32'd3, 32'd3});

    // engine full blocks issue
    ack_q.delete();
    rx_q.delete();
    full_mode = 1'b1;
    full_force = 1'b1;
    req_valid = 4'b0100;
    g = 0;
    repeat (10) begin
      tick();
      if (req_ack != '0 || mod_ien) g++;
    end
    chk("t3_blocked", g, 0);
    full_force = 1'b0;
    tick();
    chk("t3_ack", req_ack, 4'b0100);
    chk("t3_ien", mod_ien, 1);
    req_valid = '0;
    full_mode = 1'b0;
    drain(1, "t3_drain");

    // consumer stall with two frames in flight
    ack_q.delete();
    rx_q.delete();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (30) tick();
    chk("t4_nack", ack_q.size(), 3);
    chk("t4_hold", {res_valid, mod_fct}, 2'b11);
    chk("t4_count", dut.tag_count, 2);
    if (ack_q.size() > 0) chk("t4_head", res_src, ack_q[0]);
    res_ready = 1'b1;
    t = 0;
    while (ack_q.size() < 6 && t < 300) begin
      tick();
      t++;
    end
    req_valid = '0;
    drain(6, "t4_drain");
    for (int i = 0; i < 6 && i < ack_q.size(); i++) begin
      if (i > 0)
        chk($sformatf("t4_rr%0d", i), ack_q[i],
            (ack_q[i-1] + 1) % NB);
      if (i < rx_q.size()) begin
        chk($sformatf("t4_src%0d", i), rx_q[i].src, ack_q[i]);
        chk($sformatf("t4_data%0d", i),
            frame_ok(rx_q[i].d, ack_q[i], 1), 1);
      end
    end

    // issue and result return in the same cycle
    do_reset();
    rx_q.delete();
    lat = 3;
    req_valid = 4'b0011;
    wait_ack(g);
    chk("t6_first", g, 0);
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    chk("t6_ack", req_ack, 4'b0010);
    chk("t6_cnt_pre", dut.tag_count, 1);
    req_valid = '0;
    tick();
    chk("t6_cnt_post", dut.tag_count, 1);
    chk("t6_res", {res_valid, res_src}, {1'b1, 2'd0});
    drain(2, "t6_drain");
    lat = 1;
    if (rx_q.size() == 2)
      chk("t6_order", {rx_q[0].src, rx_q[1].src}, {32'd0, 32'd1});

    // reset mid-operation, then a stray engine result
    do_reset();
    rx_q.delete();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    wait_ack(g);
    req_valid = 4'b0010;
    wait_ack(g);
    chk("t5_second", g, 1);
    req_valid = '0;
    tick();
    tick();
    chk("t5_pre", {res_valid, res_src}, {1'b1, 2'd0});
    chk("t5_pre_cnt", dut.tag_count, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_outs",
        {req_ack, mod_ien, mod_ien_data, mod_fct,
         res_valid, busy, err_orphan, res_src}, 0);
    chk("t5_rst_data", (mod_idata == '0) && (res_data == '0), 1);
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (4) tick();
    chk("t5_orphan", err_orphan, 1);
    chk("t5_idle", {res_valid, busy}, 0);
    chk("t5_no_rx", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
